queue_people_counter: RTL and testbench
=======================================

Name: queue_people_counter

Overview:
- Upstream stage of the waiting-time lookup. Tracks how many customers are in the bank queue using an entry photocell and an exit photocell, and registers the active-teller count from switches.
- Presents {tcount, pcount} as a 5-bit lookup address to the wait-time table.
- Also drives the full, empty and reject status flags consumed by the display/alarm logic.

Parameters:
- PCOUNT_W, 3, queue-count width; maximum count = 2^PCOUNT_W-1 = 7.
- TCOUNT_W, 2, teller-count width.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required by the debounce filter. Only used with QPC_DEBOUNCE_EN; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- front_sensor  input  1  entry photocell, asynchronous; 1 = beam blocked.
- back_sensor  input  1  exit photocell, asynchronous; 1 = beam blocked.
- tcount_in  input  TCOUNT_W  teller-count switches, quasi-static.
- pcount  output  PCOUNT_W  registered people count.
- tcount  output  TCOUNT_W  registered teller count.
- rom_addr  output  TCOUNT_W+PCOUNT_W  {tcount, pcount}, feeds wait-time table.
- full  output  1  pcount == 7.
- empty  output  1  pcount == 0.
- reject  output  1  one-cycle pulse: an entry was dropped because the queue was full.

Behaviour:
- Reset (async assert, sync release to the next clk edge):
  - pcount=0, tcount=0, empty=1, full=0, reject=0.
  - Both sensor FSMs go to S_IDLE; synchronizer flops clear to 0.
- Sensor path, one per sensor:
  - 2-flop synchronizer.
  - Optional debounce filter.
  - Pass-detect FSM:
    - S_IDLE -> S_BLOCKED when the filtered sensor = 1.
    - S_BLOCKED -> S_IDLE when the filtered sensor = 0, emitting a one-cycle pass pulse (enter_p or exit_p) on that transition.
    - A person is counted only on beam release. Holding the beam blocked indefinitely produces no pulse.
- Latency without debounce:
  - Let E be the first clk edge that samples the sensor low.
  - The sync stages capture at E and E+1; the FSM transition and count update occur at edge E+2.
  - pcount is visible after E+2.
- Count update, evaluated each cycle:
  - enter_p only, count<7: count+1.
  - enter_p only, count==7: count unchanged; reject=1 for that cycle.
  - exit_p only, count>0: count-1.
  - exit_p only, count==0: count unchanged; no flag.
  - enter_p and exit_p together: count unchanged, including at 0 and at 7; reject=0.
  - No wrap-around in either direction.
- full and empty are decoded directly from the pcount register, with no added latency.
- tcount is registered from tcount_in every cycle (1-cycle latency). tcount=0 is legal and means no teller is open.
- rom_addr = {tcount, pcount}, purely combinational from registers.
- A blocked beam at reset release: the FSM enters S_BLOCKED once the synchronized 1 arrives, and a later release counts normally.

Optional Feature:
- Macro QPC_DEBOUNCE_EN.
- Defined:
  - Each synchronized sensor drives an 8-bit stability counter.
  - The filtered output changes only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch-free cycle, i.e. a glitch back, resets the counter.
  - The counter and filtered output reset to 0.
  - Update latency becomes E+2+DEBOUNCE_CYCLES.
- Undefined: the filtered output equals the synchronized output. No counter logic is present.

Decomposition:
- Package qpc_pkg holds:
  - PCOUNT_W, TCOUNT_W, ADDR_W=5, PCOUNT_MAX=7.
  - typedef pass_state_t {S_IDLE, S_BLOCKED}.
- Sub-module sensor_pass_detect contains the synchronizer, the optional debounce filter and the pass FSM.
  - Ports: clk, rst, sensor, pass_pulse.
  - Instantiated twice, for the front and back sensors.

Test Plan:
1. Reset with both sensors 0, then tcount_in=2 -> after 1 cycle tcount=2, pcount=0, empty=1, rom_addr=5'b10_000.
2. Three front pulses, each held high 5 cycles -> pcount=3; each increment lands exactly at E+2; rom_addr=5'b10_011.
3. Eight front pulses from 0 -> pcount saturates at 7, full=1; the 8th pulse gives a single-cycle reject=1, then pcount stays 7.
4. Back pulse at pcount=0 -> pcount stays 0, reject=0. At pcount=4, simultaneous front and back release -> pcount stays 4.
5. Front held high 100 cycles, rst asserted mid-hold, then released -> after reset pcount=0; the later beam release gives pcount=1.
6. With QPC_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: a 2-cycle front glitch -> no count change. A 10-cycle pulse -> pcount+1 at E+6.

Source files
------------

// File: rtl/qpc_pkg.sv
// Shared widths, limits and pass-FSM state type for the queue people counter.
// Pure declarations: no latency, no backpressure.
package qpc_pkg;
  localparam int PCOUNT_W = 3;
  localparam int TCOUNT_W = 2;
  localparam int ADDR_W   = TCOUNT_W + PCOUNT_W;
  localparam logic [PCOUNT_W-1:0] PCOUNT_MAX = 3'd7;

  typedef enum logic {S_IDLE, S_BLOCKED} pass_state_t;
endpackage

// File: rtl/sensor_pass_detect.sv
// Photocell sync + optional debounce (QPC_DEBOUNCE_EN) + pass FSM; pulse 2 cycles after release
// (2+DEBOUNCE_CYCLES with debounce). No backpressure: a pass pulse is never held or stalled.
module sensor_pass_detect
  import qpc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic pass_pulse
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
    $error("DEBOUNCE_CYCLES out of range 1..255");
  end

  logic        sync1;
  logic        sync2;
  logic        filt;
  pass_state_t state;
  pass_state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
    end
  end

`ifdef QPC_DEBOUNCE_EN
  logic [7:0] stable_cnt;

  // Any cycle where sync2 agrees with filt is a glitch back and restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt <= 8'd0;
      filt       <= 1'b0;
    end else if (sync2 != filt) begin
      if (stable_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        filt       <= sync2;
        stable_cnt <= 8'd0;
      end else begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end else begin
      stable_cnt <= 8'd0;
    end
  end
`else
  assign filt = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Mealy pulse so the count moves on the same edge as the FSM leaves S_BLOCKED.
  always_comb begin
    state_nxt  = state;
    pass_pulse = 1'b0;
    case (state)
      S_IDLE:    if (filt) state_nxt = S_BLOCKED;
      S_BLOCKED: if (!filt) begin
        state_nxt  = S_IDLE;
        pass_pulse = 1'b1;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/queue_people_counter.sv
// Saturating queue head-count from entry/exit photocells plus registered teller count -> {tcount,pcount}.
// Count lands 2 cycles after beam release (+DEBOUNCE_CYCLES with QPC_DEBOUNCE_EN); no backpressure.
module queue_people_counter
  import qpc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                front_sensor,
  input  logic                back_sensor,
  input  logic [TCOUNT_W-1:0] tcount_in,
  output logic [PCOUNT_W-1:0] pcount,
  output logic [TCOUNT_W-1:0] tcount,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                full,
  output logic                empty,
  output logic                reject
);

  localparam logic [PCOUNT_W-1:0] PCOUNT_ONE = 3'd1;

  logic enter_p;
  logic exit_p;

  sensor_pass_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_front (
    .clk        (clk),
    .rst        (rst),
    .sensor     (front_sensor),
    .pass_pulse (enter_p)
  );

  sensor_pass_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk        (clk),
    .rst        (rst),
    .sensor     (back_sensor),
    .pass_pulse (exit_p)
  );

  // Simultaneous entry and exit cancel; no wrap at either end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcount <= '0;
      tcount <= '0;
      reject <= 1'b0;
    end else begin
      tcount <= tcount_in;
      reject <= 1'b0;
      if (enter_p && !exit_p) begin
        if (pcount != PCOUNT_MAX) pcount <= pcount + PCOUNT_ONE;
        else                      reject <= 1'b1;
      end else if (exit_p && !enter_p && pcount != '0) begin
        pcount <= pcount - PCOUNT_ONE;
      end
    end
  end

  assign full     = (pcount == PCOUNT_MAX);
  assign empty    = (pcount == '0);
  assign rom_addr = {tcount, pcount};

endmodule

// File: tb/tb_queue_people_counter.sv
// Bench for queue_people_counter: directed scenarios plus random photocell traffic vs. a behavioural model.
// Build with QPC_DEBOUNCE_EN defined to exercise the debounce filter.
module tb_queue_people_counter;
  import qpc_pkg::*;

  localparam int DB = 4;
`ifdef QPC_DEBOUNCE_EN
  localparam int DB_EFF = DB;
  localparam int LAT    = 2 + DB;  // release sample E -> count edge
  localparam int D      = 3;       // window-complete sample -> count edge
`else
  localparam int DB_EFF = 1;
  localparam int LAT    = 2;
  localparam int D      = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       front_sensor = 1'b0;
  logic       back_sensor = 1'b0;
  logic [1:0] tcount_in = 2'd0;
  logic [2:0] pcount;
  logic [1:0] tcount;
  logic [4:0] rom_addr;
  logic       full, empty, reject;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  queue_people_counter #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .front_sensor (front_sensor),
    .back_sensor  (back_sensor),
    .tcount_in    (tcount_in),
    .pcount       (pcount),
    .tcount       (tcount),
    .rom_addr     (rom_addr),
    .full         (full),
    .empty        (empty),
    .reject       (reject)
  );

  // Reference model: a person passes when a beam's (debounced) sample stream goes 1 -> 0;
  // the count reacts a fixed number of edges later, saturating at 0 and 7.
  int         m_pcount = 0;
  logic [1:0] m_tcount = 2'd0;
  logic       m_reject = 1'b0;
  logic       m_stab [2];
  int         m_run  [2];
  logic [2:0] m_pipe [2];

  initial begin : model
    logic s    [2];
    logic outp [2];
    logic ev;
    for (int i = 0; i < 2; i++) begin
      m_stab[i] = 1'b0; m_run[i] = 0; m_pipe[i] = 3'd0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pcount = 0; m_tcount = 2'd0; m_reject = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_stab[i] = 1'b0; m_run[i] = 0; m_pipe[i] = 3'd0;
        end
      end else begin
        s[0] = front_sensor;
        s[1] = back_sensor;
        for (int i = 0; i < 2; i++) begin
          ev = 1'b0;
          if (s[i] !== m_stab[i]) begin
            m_run[i]++;
            if (m_run[i] >= DB_EFF) begin
              m_stab[i] = s[i];
              m_run[i]  = 0;
              ev        = (s[i] == 1'b0);
            end
          end else begin
            m_run[i] = 0;
          end
          outp[i]   = m_pipe[i][D-1];
          m_pipe[i] = {m_pipe[i][1:0], ev};
        end
        m_tcount = tcount_in;
        m_reject = 1'b0;
        if (outp[0] && !outp[1]) begin
          if (m_pcount < 7) m_pcount++;
          else              m_reject = 1'b1;
        end else if (outp[1] && !outp[0] && m_pcount > 0) begin
          m_pcount--;
        end
      end
    end
  end

  // Stimulus-only helpers (called right after a negedge).
  task automatic do_reset();
    rst = 1'b1; front_sensor = 1'b0; back_sensor = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic f, input logic b, input int hi);
    front_sensor = f; back_sensor = b;
    repeat (hi) @(negedge clk);
    front_sensor = 1'b0; back_sensor = 1'b0;
  endtask

  task automatic test_reset();
    tcount_in = 2'd2;
    @(negedge clk);
    checks++; if (pcount !== 3'd0) $display("FAIL reset_pcount got %0d want 0", pcount); else passes++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else passes++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else passes++;
    checks++; if (reject !== 1'b0) $display("FAIL reset_reject got %b want 0", reject); else passes++;
    checks++; if (tcount !== 2'd0) $display("FAIL reset_tcount got %0d want 0", tcount); else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tcount !== 2'd2) $display("FAIL reset_tcount_load got %0d want 2", tcount); else passes++;
    checks++; if (rom_addr !== 5'b10_000) $display("FAIL reset_rom_addr got %b want 10000", rom_addr); else passes++;
  endtask

  task automatic test_entry();
    for (int k = 0; k < 3; k++) begin
      pulse(1'b1, 1'b0, 5);
      for (int j = 1; j <= LAT + 1; j++) begin
        @(negedge clk);
        if (j == LAT) begin
          checks++; if (pcount !== 3'(k)) $display("FAIL entry_early k=%0d got %0d want %0d", k, pcount, k); else passes++;
        end
        if (j == LAT + 1) begin
          checks++; if (pcount !== 3'(k + 1)) $display("FAIL entry_edge k=%0d got %0d want %0d", k, pcount, k + 1); else passes++;
        end
      end
      repeat (3) @(negedge clk);
    end
    checks++; if (pcount !== 3'd3) $display("FAIL entry_total got %0d want 3", pcount); else passes++;
    checks++; if (rom_addr !== 5'b10_011) $display("FAIL entry_rom_addr got %b want 10011", rom_addr); else passes++;
    checks++; if (empty !== 1'b0) $display("FAIL entry_empty got %b want 0", empty); else passes++;
  endtask

  task automatic test_saturate();
    int rejects;
    rejects = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      pulse(1'b1, 1'b0, 5);
      repeat (LAT + 3) begin
        @(negedge clk);
        if (reject === 1'b1) rejects++;
        checks++; if (pcount !== 3'(m_pcount)) $display("FAIL sat_track k=%0d got %0d want %0d", k, pcount, m_pcount); else passes++;
      end
    end
    checks++; if (pcount !== 3'd7) $display("FAIL sat_pcount got %0d want 7", pcount); else passes++;
    checks++; if (full !== 1'b1) $display("FAIL sat_full got %b want 1", full); else passes++;
    checks++; if (rejects !== 1) $display("FAIL sat_reject_cycles got %0d want 1", rejects); else passes++;
    repeat (5) @(negedge clk);
    checks++; if (pcount !== 3'd7) $display("FAIL sat_hold got %0d want 7", pcount); else passes++;
  endtask

  task automatic test_underflow_simul();
    do_reset();
    pulse(1'b0, 1'b1, 5);
    repeat (LAT + 3) begin
      @(negedge clk);
      checks++; if (pcount !== 3'd0 || reject !== 1'b0)
        $display("FAIL underflow got pcount=%0d reject=%b want 0/0", pcount, reject); else passes++;
    end
    for (int k = 0; k < 4; k++) begin
      pulse(1'b1, 1'b0, 5);
      repeat (LAT + 3) @(negedge clk);
    end
    checks++; if (pcount !== 3'd4) $display("FAIL simul_pre got %0d want 4", pcount); else passes++;
    pulse(1'b1, 1'b1, 5);
    repeat (LAT + 3) begin
      @(negedge clk);
      checks++; if (pcount !== 3'd4 || reject !== 1'b0)
        $display("FAIL simul got pcount=%0d reject=%b want 4/0", pcount, reject); else passes++;
    end
  endtask

  task automatic test_hold_reset();
    front_sensor = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (48) @(negedge clk);
    checks++; if (pcount !== 3'd0) $display("FAIL hold_reset_pcount got %0d want 0", pcount); else passes++;
    checks++; if (empty !== 1'b1) $display("FAIL hold_reset_empty got %b want 1", empty); else passes++;
    front_sensor = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    checks++; if (pcount !== 3'd1) $display("FAIL hold_release got %0d want 1", pcount); else passes++;
  endtask

`ifdef QPC_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset();
    pulse(1'b1, 1'b0, 2);
    repeat (15) @(negedge clk);
    checks++; if (pcount !== 3'd0) $display("FAIL debounce_glitch got %0d want 0", pcount); else passes++;
    pulse(1'b1, 1'b0, 10);
    for (int j = 1; j <= LAT + 1; j++) begin
      @(negedge clk);
      if (j == LAT) begin
        checks++; if (pcount !== 3'd0) $display("FAIL debounce_early got %0d want 0", pcount); else passes++;
      end
      if (j == LAT + 1) begin
        checks++; if (pcount !== 3'd1) $display("FAIL debounce_edge got %0d want 1", pcount); else passes++;
      end
    end
  endtask
`endif

  task automatic test_random();
    int hold_f, hold_b;
    int fails_here;
    hold_f = 1; hold_b = 1; fails_here = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if (pcount !== 3'(m_pcount) || tcount !== m_tcount || reject !== m_reject ||
          full !== (m_pcount == 7) || empty !== (m_pcount == 0) ||
          rom_addr !== {m_tcount, 3'(m_pcount)}) begin
        fails_here++;
        if (fails_here <= 20)
          $display("FAIL random c=%0d got p=%0d t=%0d rej=%b f=%b e=%b addr=%b want p=%0d t=%0d rej=%b",
                   c, pcount, tcount, reject, full, empty, rom_addr, m_pcount, m_tcount, m_reject);
      end else begin
        passes++;
      end
      if (--hold_f == 0) begin front_sensor = ~front_sensor; hold_f = int'($urandom_range(1, 9)); end
      if (--hold_b == 0) begin back_sensor  = ~back_sensor;  hold_b = int'($urandom_range(1, 11)); end
      if ($urandom_range(0, 15) == 0) tcount_in = 2'($urandom);
    end
    front_sensor = 1'b0; back_sensor = 1'b0;
  endtask

  initial begin
    test_reset();
    test_entry();
    test_saturate();
    test_underflow_simul();
    test_hold_reset();
`ifdef QPC_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
